// File: rtl/quad_decoder_p_if.sv
// Encoder-side pins and decoded outputs of quad_decoder_p, bundled for port use.
// The master side drives pins and clear; the slave (decoder) drives the results.
interface quad_decoder_p_if #(
    parameter int CNT_W = 8
) ();
    logic             rot_a;
    logic             rot_b;
    logic             clr;
    logic             step;
    logic             dir;
    logic [CNT_W-1:0] pos;
    logic             sat;
    logic             err;

    modport master (
        output rot_a, rot_b, clr,
        input  step, dir, pos, sat, err
    );

    modport slave (
        input  rot_a, rot_b, clr,
        output step, dir, pos, sat, err
    );
endinterface

// File: rtl/quad_decoder_p.sv
// Quadrature encoder decoder: 2-FF synchronisers, per-channel debounce, x1/x2/x4
// resolution, signed position counter (wrap or saturate) and illegal-transition flag.
module quad_decoder_p #(
    parameter int CNT_W    = 8,
    parameter int FILT_CYC = 4,
    parameter int RES      = 4,
    parameter int WRAP     = 1
) (
    input  logic            clk,
    input  logic            rst,
    quad_decoder_p_if.slave bus
);
    localparam int FW    = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
    localparam int RES_E = (RES == 1 || RES == 2) ? RES : 4;
    localparam logic [FW-1:0]    FILT_LAST = FW'(FILT_CYC - 1);
    localparam logic [CNT_W-1:0] POS_MAX   = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] POS_MIN   = {1'b1, {(CNT_W-1){1'b0}}};

    // Channel vectors are packed as {A, B}.
    logic [1:0]          r_sync1, r_sync2, r_filt, r_prev;
    logic [1:0][FW-1:0]  r_fcnt;
    logic                r_step, r_dir, r_sat, r_err;
    logic [CNT_W-1:0]    r_pos;

    logic [1:0]          w_cw_succ;
    logic                w_chg, w_err, w_cw, w_legal, w_count;
    logic [CNT_W-1:0]    w_pos_nxt;
    logic                w_sat_nxt;

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values; reset is synchronous and wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_filt  <= '0;
            r_fcnt  <= '0;
        end else begin
            r_sync1 <= {bus.rot_a, bus.rot_b};
            r_sync2 <= r_sync1;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == FILT_LAST) begin
                    r_filt[i] <= r_sync2[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + FW'(1);
                end
            end
        end
    end

    // Clockwise successor of the previous Gray state: 00 -> 10 -> 11 -> 01 -> 00.
    always_comb begin
        case (r_prev)
            2'b00:   w_cw_succ = 2'b10;
            2'b10:   w_cw_succ = 2'b11;
            2'b11:   w_cw_succ = 2'b01;
            default: w_cw_succ = 2'b00;
        endcase
    end

    assign w_chg   = (r_filt != r_prev);
    assign w_err   = (r_filt == ~r_prev);
    assign w_cw    = w_chg && (r_filt == w_cw_succ);
    assign w_legal = w_chg && !w_err;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_count = w_legal;
        if (RES_E == 2) begin
            w_count = w_legal && (r_filt[1] != r_prev[1]);
        end else if (RES_E == 1) begin
            w_count = w_legal && (r_filt == 2'b00);
        end
    end

    always_comb begin
        w_pos_nxt = r_pos;
        w_sat_nxt = r_sat;
        if (w_count) begin
            if (w_cw) begin
                if (WRAP == 0 && r_pos == POS_MAX) begin
                    w_sat_nxt = 1'b1;
                end else begin
                    w_pos_nxt = r_pos + CNT_W'(1);
                    w_sat_nxt = 1'b0;
                end
            end else begin
                if (WRAP == 0 && r_pos == POS_MIN) begin
                    w_sat_nxt = 1'b1;
                end else begin
                    w_pos_nxt = r_pos - CNT_W'(1);
                    w_sat_nxt = 1'b0;
                end
            end
        end
        // A clear overrides any count landing on the same edge.
        if (bus.clr) begin
            w_pos_nxt = '0;
            w_sat_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= '0;
            r_step <= 1'b0;
            r_dir  <= 1'b0;
            r_err  <= 1'b0;
            r_sat  <= 1'b0;
            r_pos  <= '0;
        end else begin
            r_prev <= r_filt;
            r_step <= w_count;
            r_err  <= w_err;
            r_sat  <= w_sat_nxt;
            r_pos  <= w_pos_nxt;
            if (w_count) begin
                r_dir <= w_cw;
            end
        end
    end

    assign bus.step = r_step;
    assign bus.dir  = r_dir;
    assign bus.pos  = r_pos;
    assign bus.sat  = r_sat;
    assign bus.err  = r_err;
endmodule
